// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared types for the instruction buffer
package inst_buffer_pkg;

    typedef enum logic [2:0] {
        EXCP_NONE = 3'd0,
        EXCP_ADEF = 3'd1,
        EXCP_TLBR = 3'd2,
        EXCP_PIF  = 3'd3,
        EXCP_PPI  = 3'd4
    } excp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_br_taken;
        logic [31:0] pred_br_target;
        logic        have_excp;
        excp_t       excp_type;
    } ib_entry_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - fetch-side and decode-side signals of the instruction buffer
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic [1:0]       in_valid;
    logic [1:0][31:0] in_pc;
    logic [1:0][31:0] in_inst;
    logic [1:0]       in_pred_br_taken;
    logic [1:0][31:0] in_pred_br_target;
    logic [1:0]       in_have_excp;
    excp_t [1:0]      in_excp_type;
    logic             in_ready;

    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][31:0] out_inst;
    logic [1:0]       out_pred_br_taken;
    logic [1:0][31:0] out_pred_br_target;
    logic [1:0]       out_have_excp;
    excp_t [1:0]      out_excp_type;
    logic [1:0]       out_pop;

    modport slave (
        input  in_valid, in_pc, in_inst, in_pred_br_taken, in_pred_br_target,
               in_have_excp, in_excp_type, out_pop,
        output in_ready, out_valid, out_pc, out_inst, out_pred_br_taken,
               out_pred_br_target, out_have_excp, out_excp_type
    );

    modport master (
        output in_valid, in_pc, in_inst, in_pred_br_taken, in_pred_br_target,
               in_have_excp, in_excp_type, out_pop,
        input  in_ready, out_valid, out_pc, out_inst, out_pred_br_taken,
               out_pred_br_target, out_have_excp, out_excp_type
    );

endinterface

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - two-wide circular instruction buffer between fetch and decode
// Optional same-cycle empty-buffer bypass: INST_BUFFER_BYPASS_EN.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    inst_buffer_if.slave ib
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ib_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    ib_entry_t  in_ent  [2];
    ib_entry_t  st_ent  [2];
    ib_entry_t  out_ent [2];
    ib_entry_t  wr_ent  [2];
    logic       bypass;
    logic       in_ready;
    logic [1:0] out_valid, push_v, pop_v;
    logic [1:0] npush, npop, nrd, nwr, skip;

    assign in_ready = (count_q <= CW'(DEPTH - 2));

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass = (count_q == '0) && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_ent[s].pc             = ib.in_pc[s];
            in_ent[s].inst           = ib.in_inst[s];
            in_ent[s].pred_br_taken  = ib.in_pred_br_taken[s];
            in_ent[s].pred_br_target = ib.in_pred_br_target[s];
            in_ent[s].have_excp      = ib.in_have_excp[s];
            in_ent[s].excp_type      = ib.in_excp_type[s];
        end
        st_ent[0] = mem_q[head_q];
        st_ent[1] = mem_q[head_q + PW'(1)];
    end

    // While bypassing, popped input slots never touch storage; the rest land at tail.
    always_comb begin
        out_valid = bypass ? ib.in_valid : {count_q >= CW'(2), count_q >= CW'(1)};
        for (int s = 0; s < 2; s++) begin
            out_ent[s] = bypass ? in_ent[s] : st_ent[s];
        end
        push_v    = in_ready ? ib.in_valid : 2'b00;
        pop_v     = ib.out_pop & out_valid;
        npush     = popcnt2(push_v);
        npop      = popcnt2(pop_v);
        nrd       = bypass ? 2'd0 : npop;
        skip      = bypass ? npop : 2'd0;
        nwr       = npush - skip;
        wr_ent[0] = (skip == 2'd1) ? in_ent[1] : in_ent[0];
        wr_ent[1] = in_ent[1];
    end

    always_comb begin
        head_d  = head_q + PW'(nrd);
        tail_d  = tail_q + PW'(nwr);
        count_d = count_q + CW'(nwr) - CW'(nrd);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (nwr != 2'd0) mem_q[tail_q]            <= wr_ent[0];
            if (nwr == 2'd2) mem_q[tail_q + PW'(1)]   <= wr_ent[1];
        end
    end

    always_comb begin
        ib.in_ready  = in_ready;
        ib.out_valid = out_valid;
        for (int s = 0; s < 2; s++) begin
            ib.out_pc[s]             = out_ent[s].pc;
            ib.out_inst[s]           = out_ent[s].inst;
            ib.out_pred_br_taken[s]  = out_ent[s].pred_br_taken;
            ib.out_pred_br_target[s] = out_ent[s].pred_br_target;
            ib.out_have_excp[s]      = out_ent[s].have_excp;
            ib.out_excp_type[s]      = out_ent[s].excp_type;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed vector bench for inst_buffer
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    inst_buffer_if ib();

    inst_buffer #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .ib    (ib)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  pop;
        logic        fl;
        logic [1:0]  e_ov;
        logic        e_rdy;
        logic [3:0]  e_cnt;
        logic        chk_pc;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [1:0] v, logic [31:0] p0, logic [31:0] p1, logic [1:0] pop,
                                logic fl, logic [1:0] ov, logic rdy, logic [3:0] cnt, logic cp,
                                logic [31:0] e0, logic [31:0] e1);
        vec_t r;
        r.valid = v;    r.pc0 = B + p0; r.pc1 = B + p1; r.pop = pop; r.fl = fl;
        r.e_ov = ov;    r.e_rdy = rdy;  r.e_cnt = cnt;  r.chk_pc = cp;
        r.e_pc0 = B + e0; r.e_pc1 = B + e1;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(logic [1:0] v, logic [31:0] p0, logic [31:0] p1, logic [1:0] pop, logic fl);
        ib.in_valid = v;
        ib.in_pc[0] = p0;
        ib.in_pc[1] = p1;
        for (int s = 0; s < 2; s++) begin
            ib.in_inst[s]           = ib.in_pc[s] ^ 32'hdead_beef;
            ib.in_pred_br_taken[s]  = ib.in_pc[s][2];
            ib.in_pred_br_target[s] = ib.in_pc[s] + 32'h100;
            ib.in_have_excp[s]      = 1'b0;
            ib.in_excp_type[s]      = EXCP_NONE;
        end
        ib.out_pop = pop;
        flush      = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(ib.out_valid), 32'h0);
        chk("reset_in_ready", 32'(ib.in_ready), 32'h1);
        chk("reset_count", 32'(dut.count_q), 32'h0);

        tbl[0]  = mk(2'b11, 'h00, 'h04, 2'b00, 0, 2'b11, 1, 2, 1, 'h00, 'h04);
        tbl[1]  = mk(2'b11, 'h08, 'h0c, 2'b00, 0, 2'b11, 1, 4, 1, 'h00, 'h04);
        tbl[2]  = mk(2'b01, 'h10, 'h00, 2'b00, 0, 2'b11, 1, 5, 1, 'h00, 'h04);
        tbl[3]  = mk(2'b11, 'h14, 'h18, 2'b00, 0, 2'b11, 0, 7, 1, 'h00, 'h04);
        tbl[4]  = mk(2'b11, 'h20, 'h24, 2'b00, 0, 2'b11, 0, 7, 1, 'h00, 'h04);
        tbl[5]  = mk(2'b00, 'h00, 'h00, 2'b11, 0, 2'b11, 1, 5, 1, 'h08, 'h0c);
        tbl[6]  = mk(2'b00, 'h00, 'h00, 2'b11, 0, 2'b11, 1, 3, 1, 'h10, 'h14);
        tbl[7]  = mk(2'b11, 'h1c, 'h20, 2'b01, 0, 2'b11, 1, 4, 1, 'h14, 'h18);
        tbl[8]  = mk(2'b00, 'h00, 'h00, 2'b11, 0, 2'b11, 1, 2, 1, 'h1c, 'h20);
        tbl[9]  = mk(2'b00, 'h00, 'h00, 2'b01, 0, 2'b01, 1, 1, 1, 'h20, 'h00);
        tbl[10] = mk(2'b11, 'h24, 'h28, 2'b01, 0, 2'b11, 1, 2, 1, 'h24, 'h28);
        tbl[11] = mk(2'b11, 'h2c, 'h30, 2'b00, 0, 2'b11, 1, 4, 1, 'h24, 'h28);
        tbl[12] = mk(2'b01, 'h34, 'h00, 2'b00, 0, 2'b11, 1, 5, 1, 'h24, 'h28);
        tbl[13] = mk(2'b11, 'h38, 'h3c, 2'b11, 1, 2'b00, 1, 0, 0, 'h00, 'h00);
        tbl[14] = mk(2'b11, 'h40, 'h44, 2'b00, 0, 2'b11, 1, 2, 1, 'h40, 'h44);
        tbl[15] = mk(2'b00, 'h00, 'h00, 2'b11, 0, 2'b00, 1, 0, 0, 'h00, 'h00);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(tbl[i].valid, tbl[i].pc0, tbl[i].pc1, tbl[i].pop, tbl[i].fl);
            step();
            chk($sformatf("v%0d_out_valid", i), 32'(ib.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_in_ready", i), 32'(ib.in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_count", i), 32'(dut.count_q), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_pc) begin
                chk($sformatf("v%0d_pc0", i), ib.out_pc[0], tbl[i].e_pc0);
                chk($sformatf("v%0d_inst0", i), ib.out_inst[0], tbl[i].e_pc0 ^ 32'hdead_beef);
                if (tbl[i].e_ov[1])
                    chk($sformatf("v%0d_pc1", i), ib.out_pc[1], tbl[i].e_pc1);
            end
        end

        // Fill to a completely full buffer across the wrap point, then drain in order.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(2'b11, B + 32'h100 + 32'(8 * k), B + 32'h104 + 32'(8 * k), 2'b00, 1'b0);
            step();
            chk($sformatf("fill%0d_in_ready", k), 32'(ib.in_ready), (k < 3) ? 32'h1 : 32'h0);
        end
        chk("full_count", 32'(dut.count_q), 32'd8);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_pc0", k), ib.out_pc[0], B + 32'h100 + 32'(8 * k));
            chk($sformatf("drain%0d_pc1", k), ib.out_pc[1], B + 32'h104 + 32'(8 * k));
            chk($sformatf("drain%0d_tgt1", k), ib.out_pred_br_target[1], B + 32'h204 + 32'(8 * k));
            @(negedge clk);
            set_in(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
            step();
        end
        chk("drained_out_valid", 32'(ib.out_valid), 32'h0);

        // Exception-flagged entry passes through untouched.
        @(negedge clk);
        set_in(2'b01, B + 32'habc, 32'h0, 2'b00, 1'b0);
        ib.in_have_excp[0] = 1'b1;
        ib.in_excp_type[0] = EXCP_PIF;
        step();
        chk("excp_out_valid", 32'(ib.out_valid), 32'h1);
        chk("excp_have", 32'(ib.out_have_excp[0]), 32'h1);
        chk("excp_type", 32'(ib.out_excp_type[0]), 32'(EXCP_PIF));
        chk("excp_pc", ib.out_pc[0], B + 32'habc);
        chk("excp_taken", 32'(ib.out_pred_br_taken[0]), 32'h1);

        // Reset in the middle of traffic.
        @(negedge clk);
        set_in(2'b11, B + 32'h500, B + 32'h504, 2'b00, 1'b0);
        step();
        @(negedge clk);
        set_in(2'b11, B + 32'h508, B + 32'h50c, 2'b01, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out_valid", 32'(ib.out_valid), 32'h0);
        chk("midrst_in_ready", 32'(ib.in_ready), 32'h1);
        chk("midrst_count", 32'(dut.count_q), 32'h0);

`ifdef INST_BUFFER_BYPASS_EN
        @(negedge clk);
        set_in(2'b11, B + 32'h1000, B + 32'h1004, 2'b01, 1'b0);
        #1;
        chk("byp_same_out_valid", 32'(ib.out_valid), 32'h3);
        chk("byp_same_pc0", ib.out_pc[0], B + 32'h1000);
        step();
        chk("byp_next_count", 32'(dut.count_q), 32'h1);
        chk("byp_next_out_valid", 32'(ib.out_valid), 32'h1);
        chk("byp_next_pc0", ib.out_pc[0], B + 32'h1004);
`else
        @(negedge clk);
        set_in(2'b11, B + 32'h1000, B + 32'h1004, 2'b00, 1'b0);
        #1;
        chk("nobyp_same_out_valid", 32'(ib.out_valid), 32'h0);
        step();
        chk("nobyp_next_count", 32'(dut.count_q), 32'h2);
        chk("nobyp_next_out_valid", 32'(ib.out_valid), 32'h3);
        chk("nobyp_next_pc0", ib.out_pc[0], B + 32'h1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of 2, at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, discards all entries (branch mispredict / exception redirect).
REQ-005 SHALL have port in_valid, input, 2, fetch slots valid; in_valid[1] only with in_valid[0].
REQ-006 SHALL have port in_pc, input, 2x32, slot PCs.
REQ-007 SHALL have port in_inst, input, 2x32, slot instruction words.
REQ-008 SHALL have port in_pred_br_taken, input, 2, predictor taken bits.
REQ-009 SHALL have port in_pred_br_target, input, 2x32, predicted targets.
REQ-010 SHALL have port in_have_excp, input, 2, fetch exception flags.
REQ-011 SHALL have port in_excp_type, input, 2 x excp_t, fetch exception codes.
REQ-012 SHALL have port in_ready, output, 1, buffer can absorb two entries this cycle.
REQ-013 SHALL have ports out_valid (2), out_pc (2x32), out_inst (2x32), out_pred_br_taken (2), out_pred_br_target (2x32), out_have_excp (2), out_excp_type (2 x excp_t), all outputs, oldest entry in slot 0, feeding the two decoders.
REQ-014 SHALL have port out_pop, input, 2, entries consumed by decode; thermometer-coded; out_pop[i] only where out_valid[i].

Function
REQ-015 SHALL store entries in a circular array with head, tail and count registers; count width log2(DEPTH)+1.
REQ-016 SHALL drive in_ready = (DEPTH - count) >= 2, from registered state only; no combinational path from out_pop.
REQ-017 SHALL write in_valid slots at tail in order when in_ready, advancing tail by popcount(in_valid); in_valid while !in_ready is ignored.
REQ-018 SHALL drive out_valid[0] = count>=1, out_valid[1] = count>=2; out data read from head and head+1 mod DEPTH.
REQ-019 SHALL advance head by popcount(out_pop); next count = count + npush - npop, with push and pop in the same cycle both applied.
REQ-020 SHALL wrap head and tail modulo DEPTH with no bubble at the wrap point.
REQ-021 SHALL preserve program order: slot 0 before slot 1, earlier cycles before later.
REQ-022 SHALL, on flush, set head=tail=count=0 next cycle; same-cycle pushes and pops are dropped; flush has priority over push/pop.
REQ-023 SHALL have minimum push-to-out_valid latency of 1 cycle (without bypass).
REQ-024 SHALL pass entry fields unmodified; entries with have_excp set are still queued and delivered.

Reset
REQ-025 SHALL on reset set head=0, tail=0, count=0; thus out_valid=2'b00 and in_ready=1 in the first cycle after reset.
REQ-026 SHALL treat reset asserted mid-operation exactly as reset from idle; storage array contents need not be cleared.

Configuration
REQ-027 SHALL support macro INST_BUFFER_BYPASS_EN.
REQ-028 With INST_BUFFER_BYPASS_EN defined: when count==0 and !flush, in_* slots appear combinationally on out_* same cycle; popped bypassed entries are not written; unpopped ones are written at tail.
REQ-029 Without INST_BUFFER_BYPASS_EN: no in-to-out combinational path; out_* come only from storage.

Structure
REQ-030 SHALL use a shared package for excp_t and a packed ib_entry_t struct (pc, inst, pred_br_taken, pred_br_target, have_excp, excp_type).
REQ-031 SHALL be a single module; no sub-module is required.

Verification
REQ-032 Reset then push in_valid=11, pc 0x1c000000/0x1c000004 -> next cycle out_valid=11 with those PCs, in_ready=1.
REQ-033 Fill to count 7 with DEPTH=8 -> in_ready=0; push attempt ignored; pop 11 -> count 5, in_ready=1.
REQ-034 Simultaneous push 2 / pop 1 at count 3 -> count 4; head wraps from 7 to 0 with order intact.
REQ-035 Flush with in_valid=11 and out_pop=11 at count 5 -> next cycle out_valid=00, count 0, in_ready=1.
REQ-036 Push entry with in_have_excp=1 -> delivered with identical excp_type and pc.
REQ-037 With INST_BUFFER_BYPASS_EN, empty buffer, push 11, pop 01 -> same-cycle out_pc[0]=in_pc[0]; next cycle count 1 holding slot 1.
